// File: rtl/gen_stream_pkg.sv
// Shared types and defaults for the generator-stream reducer.
package gen_stream_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_COUNT_WIDTH = 32;

    // Reducer FSM states; the encoding is also exposed on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // One reduction result at the default widths.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0]       sum;
        logic [DEFAULT_COUNT_WIDTH-1:0] count;
        logic [DEFAULT_WIDTH-1:0]       max;
        logic                           ovf;
    } result_t;

endpackage

// File: rtl/stream_accum_unit.sv
// Running sum (with sticky wrap flag), saturating beat count and unsigned max.
// Pure datapath: the owner decides when to clear and when a beat counts.
module stream_accum_unit
    import gen_stream_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   __clock,
    input  logic                   __reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       sum,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [WIDTH-1:0]       max,
    output logic                   ovf
);

    logic [WIDTH:0] sum_ext;
    logic           count_sat;

    // One extra bit captures the carry-out that marks a wrap of the sum.
    assign sum_ext   = {1'b0, sum} + {1'b0, data};
    assign count_sat = &count;

    // Accumulator registers: reset and clear both zero them, enable folds in one beat.
    always_ff @(posedge __clock) begin
        if (__reset || clear) begin
            sum   <= '0;
            count <= '0;
            max   <= '0;
            ovf   <= 1'b0;
        end else if (enable) begin
            sum <= sum_ext[WIDTH-1:0];
            ovf <= ovf | sum_ext[WIDTH];
            if (!count_sat) begin
                count <= count + COUNT_WIDTH'(1);
            end
            if (data > max) begin
                max <= data;
            end
        end
    end

endmodule

// File: rtl/gen_stream_reducer.sv
// Consumer for a generator stream: accumulates sum/count/max of data beats and,
// on the done-beat, presents a single result beat on a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising clock edge where both the sender's
// valid and the receiver's ready are high. __input_ready depends on state only,
// and __valid/__done/__output_* stay stable while __valid is high and __ready low.
module gen_stream_reducer
    import gen_stream_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   __clock,
    input  logic                   __reset,
    input  logic                   __start,
    input  logic                   __input_valid,
    input  logic                   __input_done,
    input  logic [WIDTH-1:0]       __input_0,
    output logic                   __input_ready,
    input  logic                   __ready,
    output logic                   __valid,
    output logic                   __done,
    output logic [WIDTH-1:0]       __output_0,
    output logic [COUNT_WIDTH-1:0] __output_1,
    output logic [WIDTH-1:0]       __output_2,
    output logic                   __output_3,
    output logic [1:0]             __dbg_state
);

    state_t state_q;
    state_t state_d;

    logic acc_clear;
    logic acc_enable;
    logic result_load;

    logic [WIDTH-1:0]       acc_sum;
    logic [COUNT_WIDTH-1:0] acc_count;
    logic [WIDTH-1:0]       acc_max;
    logic                   acc_ovf;

    stream_accum_unit #(
        .WIDTH      (WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_accum (
        .__clock(__clock),
        .__reset(__reset),
        .clear  (acc_clear),
        .enable (acc_enable),
        .data   (__input_0),
        .sum    (acc_sum),
        .count  (acc_count),
        .max    (acc_max),
        .ovf    (acc_ovf)
    );

    // State register; reset wins over everything and drops any partial result.
    always_ff @(posedge __clock) begin
        if (__reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes. __start only matters in IDLE, so a start
    // seen in ACCUM or EMIT is simply dropped rather than remembered.
    always_comb begin
        state_d     = state_q;
        acc_clear   = 1'b0;
        acc_enable  = 1'b0;
        result_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (__start) begin
                    acc_clear = 1'b1;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (__input_valid) begin
                    if (__input_done) begin
                        result_load = 1'b1;
                        state_d     = ST_EMIT;
                    end else begin
                        acc_enable = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (__ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result registers: captured on the done-beat, held through EMIT and after it.
    always_ff @(posedge __clock) begin
        if (__reset) begin
            __output_0 <= '0;
            __output_1 <= '0;
            __output_2 <= '0;
            __output_3 <= 1'b0;
        end else if (result_load) begin
            __output_0 <= acc_sum;
            __output_1 <= acc_count;
            __output_2 <= acc_max;
            __output_3 <= acc_ovf;
        end
    end

    // Handshake outputs decode straight from state, so they cannot glitch on inputs.
    assign __input_ready = (state_q == ST_ACCUM);
    assign __valid       = (state_q == ST_EMIT);
    assign __done        = (state_q == ST_EMIT);
    assign __dbg_state   = state_q;

endmodule

// File: tb/tb_gen_stream_reducer.sv
// Directed-plus-random bench for gen_stream_reducer with a list-based reference model.
module tb_gen_stream_reducer;
    import gen_stream_pkg::*;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start;
    logic          in_valid;
    logic          in_done;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          ready;
    logic          valid;
    logic          done;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_count;
    logic [W-1:0]  out_max;
    logic          out_ovf;
    logic [1:0]    dbg_state;

    gen_stream_reducer #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .__clock      (clk),
        .__reset      (rst),
        .__start      (start),
        .__input_valid(in_valid),
        .__input_done (in_done),
        .__input_0    (in_data),
        .__input_ready(in_ready),
        .__ready      (ready),
        .__valid      (valid),
        .__done       (done),
        .__output_0   (out_sum),
        .__output_1   (out_count),
        .__output_2   (out_max),
        .__output_3   (out_ovf),
        .__dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] beats[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: true mathematical sum of the data beats, reduced afterwards.
    task automatic model_push();
        longint unsigned total = 0;
        logic [W-1:0]    mx = '0;
        int              n = beats.size();
        foreach (beats[i]) begin
            total += longint'(beats[i]);
            if (beats[i] > mx) mx = beats[i];
        end
        exp_q.push_back(total[W-1:0]);
        exp_q.push_back((n > CNT_MAX) ? W'(CNT_MAX) : W'(n));
        exp_q.push_back(mx);
        exp_q.push_back((total >> W) != 0 ? W'(1) : W'(0));
    endtask

    // ---------------- drivers (enter and leave at a negedge) ----------------
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_to_accum", dbg_state, ST_ACCUM);
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic dn);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_done  = dn;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("input_ready_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_done  = 1'($urandom_range(0, 1));
        repeat (n) @(negedge clk);
    endtask

    task automatic send_stream(input int max_gap);
        foreach (beats[i]) begin
            drive_beat(beats[i], 1'b0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        drive_beat($urandom, 1'b1);
        in_valid = 1'b0;
        model_push();
    endtask

    // Called at the negedge right after the done-beat was accepted.
    task automatic expect_result(input string tag, input int hold);
        logic [W-1:0] e_sum, e_cnt, e_max, e_ovf;
        e_sum = exp_q.pop_front();
        e_cnt = exp_q.pop_front();
        e_max = exp_q.pop_front();
        e_ovf = exp_q.pop_front();
        check({tag, "_valid"}, valid, 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, out_sum, e_sum);
        check({tag, "_count"}, out_count, e_cnt);
        check({tag, "_max"}, out_max, e_max);
        check({tag, "_ovf"}, out_ovf, e_ovf);
        check({tag, "_in_ready_emit"}, in_ready, 0);
        ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = (i == 0);
            @(negedge clk);
            check({tag, "_hold_valid"}, valid, 1);
            check({tag, "_hold_sum"}, out_sum, e_sum);
            check({tag, "_hold_max"}, out_max, e_max);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, "_valid_drop"}, valid, 0);
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_back_idle"}, dbg_state, ST_IDLE);
        check({tag, "_sum_kept"}, out_sum, e_sum);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_done = 1'b0; in_data = '0; ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_sum", out_sum, 0);
        check("rst_count", out_count, 0);
        check("rst_max", out_max, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        // Beats offered while IDLE are not taken and do not start anything.
        in_valid = 1'b1; in_data = 32'd99; in_done = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        check("idle_stays", dbg_state, ST_IDLE);
        in_valid = 1'b0;

        // Basic reduction, back-to-back beats.
        beats = '{32'd1, 32'd1, 32'd3, 32'd5};
        do_start();
        send_stream(0);
        expect_result("basic", 0);

        // Empty stream right after the previous EMIT exit.
        beats = '{};
        do_start();
        drive_beat(32'd0, 1'b1);
        in_valid = 1'b0;
        model_push();
        expect_result("empty", 0);

        // Wrap of the sum.
        beats = '{32'hFFFF_FFFF, 32'h2};
        do_start();
        send_stream(1);
        expect_result("ovf", 0);

        // Output backpressure with a start pulse during EMIT.
        beats = '{32'($urandom), 32'($urandom_range(0, 100)), 32'($urandom)};
        do_start();
        send_stream(2);
        expect_result("bp", 5);

        // Reset mid-stream discards the partial result and the old outputs.
        do_start();
        drive_beat(32'd7, 1'b0);
        drive_beat(32'd9, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_sum", out_sum, 0);
        check("midrst_count", out_count, 0);
        check("midrst_max", out_max, 0);
        check("midrst_in_ready", in_ready, 0);
        beats = '{32'd4};
        do_start();
        send_stream(0);
        expect_result("after_rst", 0);

        // Reset during EMIT drops the result beat.
        beats = '{32'd11, 32'd12};
        do_start();
        send_stream(0);
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        check("emit_rst_pre_valid", valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("emit_rst_valid", valid, 0);
        check("emit_rst_sum", out_sum, 0);

        // Count saturation at the counter width.
        beats = '{};
        for (int i = 0; i < CNT_MAX + 3; i++) beats.push_back(32'd1);
        do_start();
        send_stream(0);
        expect_result("sat", 0);

        // Even-Fibonacci producer, n = 10, with a stray start in ACCUM.
        begin
            longint unsigned a = 1, b = 1, c;
            beats = '{};
            while (beats.size() < 10) begin
                if (a % 2 == 0) beats.push_back(a[W-1:0]);
                c = a + b; a = b; b = c;
            end
        end
        do_start();
        foreach (beats[i]) begin
            drive_beat(beats[i], 1'b0);
            if (i == 4) begin
                start = 1'b1;
                idle(1);
                start = 1'b0;
                check("fib_start_ignored", dbg_state, ST_ACCUM);
            end else begin
                idle($urandom_range(0, 1));
            end
        end
        drive_beat(32'd0, 1'b1);
        in_valid = 1'b0;
        model_push();
        expect_result("fib", 1);

        // Random streams.
        for (int r = 0; r < 8; r++) begin
            int len = $urandom_range(0, 8);
            beats = '{};
            for (int i = 0; i < len; i++)
                beats.push_back(($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
            do_start();
            send_stream(2);
            expect_result("rand", $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
